// File: rtl/vending_machine_param.sv
// ---------------------------------------------------------------------------
// vending_machine_param
//   Vending controller placed between a coin acceptor and a dispenser.
//   Three selectable items with parameterised prices. Accepts nickel, dime and
//   quarter pulses, and tracks credit in 5c units. Coins that would overflow
//   MAX_CREDIT are returned. Change and refunds go out one coin per cycle,
//   10c first, then 5c.
//
// Ports
//   clk          in   rising-edge system clock
//   rst          in   synchronous active-low reset
//   nickel       in   5c coin pulse
//   dime         in   10c coin pulse
//   quarter      in   25c coin pulse
//   cancel       in   abort the transaction and refund the credit
//   item_select  in   00 none, 01/10/11 selects item 1/2/3
//   vend         out  1-cycle dispense pulse
//   vend_item    out  dispensed item code, valid while vend=1, else 00
//   change_5C    out  eject one 5c coin this cycle
//   change_10C   out  eject one 10c coin this cycle
//   coin_reject  out  1-cycle pulse: inserted coin(s) returned unaccepted
//   busy         out  high whenever the machine is not idle
//   credit       out  current accepted credit, 5c units
// ---------------------------------------------------------------------------
module vending_machine_param #(
  parameter int CREDIT_W   = 4,
  parameter int MAX_CREDIT = 10,
  parameter int PRICE_1    = 3,
  parameter int PRICE_2    = 4,
  parameter int PRICE_3    = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                nickel,
  input  logic                dime,
  input  logic                quarter,
  input  logic                cancel,
  input  logic [1:0]          item_select,
  output logic                vend,
  output logic [1:0]          vend_item,
  output logic                change_5C,
  output logic                change_10C,
  output logic                coin_reject,
  output logic                busy,
  output logic [CREDIT_W-1:0] credit
);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_CHANGE} state_e;

  // One spare bit so that credit + coin can never wrap before the compare.
  localparam int SUM_W = CREDIT_W + 1;
  localparam logic [SUM_W-1:0] MAX_S = SUM_W'(MAX_CREDIT);

  state_e              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [CREDIT_W-1:0] change_due_q, change_due_d;
  logic [1:0]          item_q, item_d;
  logic                vend_q, vend_d;
  logic [1:0]          vend_item_q, vend_item_d;
  logic                coin_reject_q, coin_reject_d;

  logic [1:0]       coin_cnt;
  logic             any_coin;
  logic [SUM_W-1:0] coin_val;
  logic [SUM_W-1:0] price;
  logic [SUM_W-1:0] sum;
  logic [SUM_W-1:0] excess;

  always_comb begin
    coin_cnt = {1'b0, nickel} + {1'b0, dime} + {1'b0, quarter};
    any_coin = nickel | dime | quarter;

    // Only consulted when exactly one coin line is high.
    coin_val = '0;
    if (nickel)  coin_val = SUM_W'(1);
    if (dime)    coin_val = SUM_W'(2);
    if (quarter) coin_val = SUM_W'(5);

    case (item_q)
      2'b01:   price = SUM_W'(PRICE_1);
      2'b10:   price = SUM_W'(PRICE_2);
      2'b11:   price = SUM_W'(PRICE_3);
      default: price = '0;
    endcase

    sum    = {1'b0, credit_q} + coin_val;
    excess = sum - price;
  end

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    state_d       = state_q;
    credit_d      = credit_q;
    change_due_d  = change_due_q;
    item_d        = item_q;
    vend_d        = 1'b0;
    vend_item_d   = 2'b00;
    coin_reject_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        coin_reject_d = any_coin;
        if (item_select != 2'b00) begin
          item_d  = item_select;
          state_d = S_COLLECT;
        end
      end

      S_COLLECT: begin
        if (cancel) begin
          // A coin arriving together with cancel is never credited.
          coin_reject_d = any_coin;
          change_due_d  = credit_q;
          credit_d      = '0;
          item_d        = 2'b00;
          state_d       = (credit_q != '0) ? S_CHANGE : S_IDLE;
        end else if (coin_cnt > 2'd1) begin
          coin_reject_d = 1'b1;
        end else if (coin_cnt == 2'd1) begin
          if (sum > MAX_S) begin
            coin_reject_d = 1'b1;
          end else if (sum >= price) begin
            vend_d       = 1'b1;
            vend_item_d  = item_q;
            change_due_d = excess[CREDIT_W-1:0];
            credit_d     = '0;
            item_d       = 2'b00;
            state_d      = (excess != '0) ? S_CHANGE : S_IDLE;
          end else begin
            credit_d = sum[CREDIT_W-1:0];
          end
        end
      end

      S_CHANGE: begin
        coin_reject_d = any_coin;
        if (change_due_q >= CREDIT_W'(2)) change_due_d = change_due_q - CREDIT_W'(2);
        else                              change_due_d = '0;
        if (change_due_d == '0) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      credit_q      <= '0;
      change_due_q  <= '0;
      item_q        <= 2'b00;
      vend_q        <= 1'b0;
      vend_item_q   <= 2'b00;
      coin_reject_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      credit_q      <= credit_d;
      change_due_q  <= change_due_d;
      item_q        <= item_d;
      vend_q        <= vend_d;
      vend_item_q   <= vend_item_d;
      coin_reject_q <= coin_reject_d;
    end
  end

  // Change coins are a Moore decode of the amount still owed, so the first
  // coin appears in the same cycle as the vend pulse.
  assign change_10C  = (state_q == S_CHANGE) && (change_due_q >= CREDIT_W'(2));
  assign change_5C   = (state_q == S_CHANGE) && (change_due_q == CREDIT_W'(1));
  assign vend        = vend_q;
  assign vend_item   = vend_item_q;
  assign coin_reject = coin_reject_q;
  assign busy        = (state_q != S_IDLE);
  assign credit      = credit_q;

endmodule
